// File: rtl/bram_fifo_pkg.sv
// Shared request-classification type for the BRAM FIFO controller.
// Depth and width are set by module parameters only.
package bram_fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/bram_dual_negedge.sv
// Simple dual-port RAM: rising-edge write, falling-edge registered read.
// A read issued on the falling edge is settled by the following rising edge.
module bram_dual_negedge #(
    parameter int addrWidth_p = 8,
    parameter int dataWidth_p = 16
) (
    input  logic                   clk_i,
    input  logic                   wr_en,
    input  logic [addrWidth_p-1:0] wr_addr,
    input  logic [dataWidth_p-1:0] wr_data,
    input  logic [addrWidth_p-1:0] rd_addr,
    output logic [dataWidth_p-1:0] rd_data
);

    logic [dataWidth_p-1:0] mem [2**addrWidth_p];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(negedge clk_i) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/bram_fifo.sv
// First-word-fall-through FIFO: pointers, count and sticky error flags live here,
// entries live in a single falling-edge-read BRAM.
module bram_fifo
    import bram_fifo_pkg::*;
#(
    parameter int memSize_p   = 8,
    parameter int dataWidth_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   write_i,
    input  logic [dataWidth_p-1:0] data_i,
    input  logic                   read_i,
    output logic [dataWidth_p-1:0] data_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [memSize_p:0]     count_o,
    output logic                   overflow_o,
    output logic                   underflow_o
);

    localparam int unsigned         DEPTH    = 2**memSize_p;
    localparam logic [memSize_p:0]  DEPTH_C  = DEPTH[memSize_p:0];
    localparam logic [memSize_p:0]  CNT_ONE  = 1;
    localparam logic [memSize_p-1:0] PTR_ONE = 1;

    logic [memSize_p-1:0] wptr;
    logic [memSize_p-1:0] rptr;
    logic [memSize_p:0]   count_q;
    logic [memSize_p:0]   count_next;
    logic                 empty_q;
    logic                 full_q;
    logic                 overflow_q;
    logic                 underflow_q;
    logic                 push_ok;
    logic                 pop_ok;
    fifo_op_e             op;

    // Acceptance uses the registered flags, so a full FIFO rejects a push
    // even when a pop is accepted in the same cycle.
    assign push_ok = write_i && !full_q;
    assign pop_ok  = read_i  && !empty_q;
    assign op      = fifo_op_e'({push_ok, pop_ok});

    always_comb begin
        count_next = count_q;
        case (op)
            OP_PUSH: count_next = count_q + CNT_ONE;
            OP_POP:  count_next = count_q - CNT_ONE;
            default: count_next = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr        <= '0;
            rptr        <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop_ok) begin
                rptr <= rptr + PTR_ONE;
            end
            count_q <= count_next;
            empty_q <= (count_next == '0);
            full_q  <= (count_next == DEPTH_C);
            if (write_i && full_q) begin
                overflow_q <= 1'b1;
            end
            if (read_i && empty_q) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // rptr already holds the post-edge read pointer when the falling-edge read fires.
    bram_dual_negedge #(
        .addrWidth_p(memSize_p),
        .dataWidth_p(dataWidth_p)
    ) u_mem (
        .clk_i   (clk_i),
        .wr_en   (push_ok && !reset_i),
        .wr_addr (wptr),
        .wr_data (data_i),
        .rd_addr (rptr),
        .rd_data (data_o)
    );

    assign empty_o     = empty_q;
    assign full_o      = full_q;
    assign count_o     = count_q;
    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;

endmodule

// File: tb/tb_bram_fifo.sv
// Self-checking bench for bram_fifo (depth 4, 8-bit entries) against a queue model.
module tb_bram_fifo;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       write_i;
    logic [7:0] data_i;
    logic       read_i;
    logic [7:0] data_o;
    logic       empty_o;
    logic       full_o;
    logic [2:0] count_o;
    logic       overflow_o;
    logic       underflow_o;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic       ovf_m;
    logic       unf_m;

    always #5 clk_i = ~clk_i;

    bram_fifo #(.memSize_p(2), .dataWidth_p(8)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .write_i    (write_i),
        .data_i     (data_i),
        .read_i     (read_i),
        .data_o     (data_o),
        .empty_o    (empty_o),
        .full_o     (full_o),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .underflow_o(underflow_o)
    );

    // Drive one cycle, advance the model at the rising edge, then settle past the falling edge.
    task automatic step(input logic w, input logic r, input logic rst, input logic [7:0] d);
        bit full_m, empty_m;
        write_i = w;
        read_i  = r;
        reset_i = rst;
        data_i  = d;
        @(posedge clk_i);
        full_m  = (q.size() == 4);
        empty_m = (q.size() == 0);
        if (rst) begin
            q.delete();
            ovf_m = 1'b0;
            unf_m = 1'b0;
        end else begin
            if (w && full_m) ovf_m = 1'b1;
            if (r && empty_m) unf_m = 1'b1;
            if (r && !empty_m) void'(q.pop_front());
            if (w && !full_m) q.push_back(d);
        end
        #7;
        write_i = 1'b0;
        read_i  = 1'b0;
        reset_i = 1'b0;
    endtask

    task automatic test_reset();
        step(0, 0, 1, 8'h00);
        checks++; if (count_o !== 3'd0)    begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (empty_o !== 1'b1)    begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty_o); end
        checks++; if (full_o !== 1'b0)     begin failures++; $display("FAIL reset_full got=%0b exp=0", full_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", overflow_o); end
        checks++; if (underflow_o !== 1'b0) begin failures++; $display("FAIL reset_unf got=%0b exp=0", underflow_o); end
    endtask

    task automatic test_underflow();
        step(0, 1, 0, 8'h00);
        checks++; if (underflow_o !== 1'b1) begin failures++; $display("FAIL unf_flag got=%0b exp=1", underflow_o); end
        checks++; if (count_o !== 3'd0)     begin failures++; $display("FAIL unf_count got=%0d exp=0", count_o); end
        step(1, 0, 0, 8'hA5);
        checks++; if (data_o !== 8'hA5)  begin failures++; $display("FAIL unf_fwft_data got=%0h exp=a5", data_o); end
        checks++; if (empty_o !== 1'b0)  begin failures++; $display("FAIL unf_fwft_empty got=%0b exp=0", empty_o); end
        checks++; if (underflow_o !== 1'b1) begin failures++; $display("FAIL unf_sticky got=%0b exp=1", underflow_o); end
    endtask

    task automatic fill4();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 0, vals[i]);
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        fill4();
        checks++; if (full_o !== 1'b1)  begin failures++; $display("FAIL fill_full got=%0b exp=1", full_o); end
        checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count_o); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (data_o !== vals[i]) begin failures++; $display("FAIL drain_data[%0d] got=%0h exp=%0h", i, data_o, vals[i]); end
            step(0, 1, 0, 8'h00);
        end
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL drain_empty got=%0b exp=1", empty_o); end
    endtask

    task automatic test_overflow();
        fill4();
        step(1, 0, 0, 8'h55);
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", overflow_o); end
        checks++; if (count_o !== 3'd4)    begin failures++; $display("FAIL ovf_count got=%0d exp=4", count_o); end
        checks++; if (data_o !== 8'h11)    begin failures++; $display("FAIL ovf_head got=%0h exp=11", data_o); end
        for (int i = 0; i < 4; i++) step(0, 1, 0, 8'h00);
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL ovf_no_extra got=%0b exp=1", empty_o); end
    endtask

    task automatic test_full_both();
        fill4();
        step(1, 1, 0, 8'h66);
        checks++; if (count_o !== 3'd3)    begin failures++; $display("FAIL fb_count got=%0d exp=3", count_o); end
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL fb_ovf got=%0b exp=1", overflow_o); end
        checks++; if (data_o !== 8'h22)    begin failures++; $display("FAIL fb_head got=%0h exp=22", data_o); end
    endtask

    task automatic test_simultaneous();
        step(0, 0, 1, 8'h00);
        step(1, 0, 0, 8'd1);
        step(1, 0, 0, 8'd2);
        for (int k = 1; k <= 10; k++) begin
            step(1, 1, 0, 8'(k + 2));
            checks++;
            if (count_o !== 3'd2) begin failures++; $display("FAIL simul_count[%0d] got=%0d exp=2", k, count_o); end
            checks++;
            if (data_o !== 8'(k + 1)) begin failures++; $display("FAIL simul_data[%0d] got=%0h exp=%0h", k, data_o, 8'(k + 1)); end
        end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 1, 8'h00);
        step(0, 1, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'(8'h30 + i));
        step(1, 0, 0, 8'hEE);
        step(0, 1, 0, 8'h00);
        checks++;
        if (count_o !== 3'd3 || overflow_o !== 1'b1 || underflow_o !== 1'b1) begin
            failures++; $display("FAIL mid_setup got=%0d/%0b/%0b exp=3/1/1", count_o, overflow_o, underflow_o);
        end
        step(1, 1, 1, 8'hDD);
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL mid_count got=%0d exp=0", count_o); end
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL mid_empty got=%0b exp=1", empty_o); end
        checks++;
        if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
            failures++; $display("FAIL mid_flags got=%0b%0b exp=00", overflow_o, underflow_o);
        end
        step(1, 0, 0, 8'h77);
        checks++; if (data_o !== 8'h77) begin failures++; $display("FAIL mid_readback got=%0h exp=77", data_o); end
    endtask

    task automatic test_random();
        step(0, 0, 1, 8'h00);
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0), 8'($urandom));
            checks++;
            if (count_o !== 3'(q.size()) || empty_o !== (q.size() == 0) || full_o !== (q.size() == 4) ||
                overflow_o !== ovf_m || underflow_o !== unf_m) begin
                failures++;
                $display("FAIL rand_state[%0d] got=%0d/%0b/%0b/%0b/%0b exp=%0d/%0b/%0b/%0b/%0b", i,
                         count_o, empty_o, full_o, overflow_o, underflow_o,
                         q.size(), q.size() == 0, q.size() == 4, ovf_m, unf_m);
            end
            if (q.size() != 0) begin
                checks++;
                if (data_o !== q[0]) begin failures++; $display("FAIL rand_data[%0d] got=%0h exp=%0h", i, data_o, q[0]); end
            end
        end
    endtask

    initial begin
        reset_i = 1'b1;
        write_i = 1'b0;
        read_i  = 1'b0;
        data_i  = '0;
        ovf_m   = 1'b0;
        unf_m   = 1'b0;
        test_reset();
        test_underflow();
        test_fill_drain();
        test_overflow();
        test_full_both();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
